pipelined_ram: RTL and testbench
================================

# pipelined_ram

Parametrised single-port synchronous memory with a valid/ready request channel, configurable read latency, byte-enable writes and a hardware clear sequencer. It is the clocked successor to the combinational instruction/data RAM and serves as both instruction and data memory of the MIPS pipeline. The clear sequencer replaces the zero-delay for-loop clear with a bounded, cycle-counted initialisation walk.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 7, word-address width; depth is 2**ADDR_W words.
- READ_LAT, 1, read latency in cycles; legal values are 1 to 3.
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- init_req  in  1  single-cycle pulse that re-runs the clear sequence.
- req_valid  in  1  a request is presented.
- req_ready  out  1  the memory accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  DATA_W/8  byte enables for writes; bit i covers data bits [8i+7:8i]; ignored on reads.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data is valid this cycle.
- rsp_rdata  out  DATA_W  read data; all zeros when rsp_valid=0.
- init_busy  out  1  the clear/boot sequence is in progress.

## Operation
- FSM states: CLEAR, BOOT, READY. BOOT exists only with the boot macro.
- Reset values: state=CLEAR, walk counter=0, init_busy=1, req_ready=0, rsp_valid=0, rsp_rdata=0, read pipeline valids=0.
- CLEAR: writes 0 to word[counter] once per cycle.
  - When counter = 2**ADDR_W-1: go to BOOT if the macro is defined, otherwise READY.
  - Counter width is ADDR_W+1 so the terminal compare does not wrap.
- BOOT: writes BOOT_IMAGE[k] to word[k] for k=0..7, one word per cycle, then goes to READY.
- READY: req_ready=1 and init_busy=0.
- A request is accepted when req_valid && req_ready. At most one request per cycle.
- Write: for each set bit of req_be, updates that byte of word[req_addr]. req_be=0 is a legal no-op. Writes produce no response.
- Read: enters a READ_LAT-deep shift pipeline.
  - rsp_valid/rsp_rdata appear exactly READ_LAT cycles after acceptance.
  - Fully pipelined; back-to-back reads give back-to-back responses.
  - There is no response backpressure.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. The array update is visible from the next edge; no bypass is needed.
- init_req in READY:
  - State goes to CLEAR and the counter to 0 on the next edge.
  - req_ready drops in that cycle's successor.
  - Reads already in the pipeline still complete, with data sampled at their acceptance.
  - A request accepted in the same cycle as init_req is performed.
- init_req during CLEAR or BOOT: ignored.
- reset mid-operation: in-flight reads are dropped (no rsp_valid) and the sequence restarts at CLEAR with counter 0.

## Timing
- First req_ready=1 comes 2**ADDR_W cycles after reset deassertion (128 at default), plus 8 cycles with the boot macro.
- init_req restart costs the same count from its accepting edge.
- Read latency is exactly READ_LAT edges from the acceptance edge. Write-to-visible latency is 1 edge.
- req_ready is a registered function of state only. It never depends combinationally on req_valid.

## Configuration
- RAM_BOOT_PROGRAM_EN defined:
  - BOOT state is present and init_busy covers CLEAR+BOOT.
  - Words 0..7 after init are 0x00000000, 0x2129000A, 0x214A0005, 0x00000000, 0x00000000, 0x00000000, 0x012A4020, 0x2108000A.
- RAM_BOOT_PROGRAM_EN undefined:
  - BOOT state is absent and CLEAR goes straight to READY.
  - All words read 0 after init.

## Structure
- Shared package ram_pkg holds:
  - the state enum (CLEAR, BOOT, READY);
  - BOOT_IMAGE, an 8-entry array of 32-bit words;
  - BOOT_LEN = 8.
- One sub-module: ram_read_pipe, a READ_LAT-stage valid/data shift register that clears its valids on reset.
- Array write arbitration between the sequencer and the request port stays in the top module. The sequencer has priority, since req_ready=0 during init.

## Test plan
- Reset, then hold req_valid=0 -> init_busy=1 for 128 cycles (136 with macro), then req_ready=1; reads of all 128 words return 0 (boot image at 0..7 with macro).
- Write addr 5, data 0xDEADBEEF, be=0xF; next cycle read addr 5 -> rsp_valid exactly READ_LAT cycles later with 0xDEADBEEF.
- Write 0xFFFFFFFF then write 0x12345678 with be=0b0101 to addr 9; read -> 0xFF34FF78.
- Reads of addr 0..15 on 16 consecutive cycles with READ_LAT=3 -> 16 consecutive rsp_valid cycles, data in address order, no gaps.
- Issue 2 reads, then init_req in the next cycle -> both responses arrive with pre-clear data; req_ready=0 for 128 cycles; a later read returns 0.
- Assert reset while 2 reads are in flight -> no rsp_valid; init restarts from counter 0 and the full clear count is observed again.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for pipelined_ram: sequencer states and the
// optional boot program loaded after the clear walk.
package ram_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_BOOT  = 2'd1,
      ST_READY = 2'd2
   } ram_state_e;

   localparam int BOOT_LEN = 8;

   localparam logic [31:0] BOOT_IMAGE [BOOT_LEN] = '{
      32'h0000_0000, 32'h2129_000A, 32'h214A_0005, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'h012A_4020, 32'h2108_000A
   };

endpackage

// File: rtl/ram_read_pipe.sv
// READ_LAT-deep valid/data shift register carrying read data sampled at
// acceptance out to the response port; valids clear on reset.
module ram_read_pipe #(
   parameter int DATA_W = 32,
   parameter int LAT    = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [LAT-1:0]    valid_q;
   logic [DATA_W-1:0] data_q [LAT];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < LAT; i++) data_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         data_q[0]  <= in_data;
         for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[LAT-1];
   assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/pipelined_ram.sv
// Single-port synchronous RAM with valid/ready requests, byte-enable writes,
// pipelined reads and a clear sequencer. RAM_BOOT_PROGRAM_EN adds a BOOT walk.
module pipelined_ram
   import ram_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 7,
   parameter int READ_LAT = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                init_req,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                init_busy,
   output logic [1:0]          dbg_state_o
);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_ready is registered from the next state and never looks at req_valid.
   // Responses carry no ready: rsp_valid is a one-cycle strobe per accepted read.

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);
`ifdef RAM_BOOT_PROGRAM_EN
   localparam logic [CNT_W-1:0] LAST_BOOT = CNT_W'(BOOT_LEN - 1);
`endif

   logic [DATA_W-1:0] mem_q [DEPTH];

   ram_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q, busy_q;
   logic              seq_we;
   logic [ADDR_W-1:0] seq_addr;
   logic [DATA_W-1:0] seq_wdata;
   logic              wr_fire, rd_fire;
   logic              pipe_valid;
   logic [DATA_W-1:0] pipe_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == ST_READY);
         busy_q  <= (state_d != ST_READY);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      seq_we    = 1'b0;
      seq_addr  = cnt_q[ADDR_W-1:0];
      seq_wdata = '0;
      case (state_q)
         ST_CLEAR: begin
            seq_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
               cnt_d = '0;
`ifdef RAM_BOOT_PROGRAM_EN
               state_d = ST_BOOT;
`else
               state_d = ST_READY;
`endif
            end
         end
`ifdef RAM_BOOT_PROGRAM_EN
         ST_BOOT: begin
            seq_we    = 1'b1;
            seq_wdata = DATA_W'(BOOT_IMAGE[cnt_q[2:0]]);
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_BOOT) begin
               cnt_d   = '0;
               state_d = ST_READY;
            end
         end
`endif
         ST_READY: begin
            if (init_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   assign wr_fire = req_valid && ready_q && req_we;
   assign rd_fire = req_valid && ready_q && !req_we;

   // The sequencer only writes while req_ready is low, so it never collides with the port.
   always_ff @(posedge clock) begin
      if (seq_we) begin
         mem_q[seq_addr] <= seq_wdata;
      end else if (wr_fire) begin
         for (int b = 0; b < NB; b++) begin
            if (req_be[b]) mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   ram_read_pipe #(
      .DATA_W (DATA_W),
      .LAT    (READ_LAT)
   ) u_read_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (rd_fire),
      .in_data   (mem_q[req_addr]),
      .out_valid (pipe_valid),
      .out_data  (pipe_data)
   );

   assign req_ready   = ready_q;
   assign init_busy   = busy_q;
   assign rsp_valid   = pipe_valid;
   assign rsp_rdata   = pipe_valid ? pipe_data : '0;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipelined_ram.sv
// Self-checking bench for pipelined_ram (READ_LAT=3): directed and random
// requests against a word-array model with a due-cycle response scoreboard.
module tb_pipelined_ram;
   import ram_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 7;
   localparam int LAT   = 3;
   localparam int DEPTH = 128;
`ifdef RAM_BOOT_PROGRAM_EN
   localparam int INIT  = DEPTH + 8;
`else
   localparam int INIT  = DEPTH;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          init_req = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [3:0]    req_be = '0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          init_busy;
   logic [1:0]    dbg_state;

   pipelined_ram #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT)) dut (
      .clock       (clock),
      .reset       (reset),
      .init_req    (init_req),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_be      (req_be),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .init_busy   (init_busy),
      .dbg_state_o (dbg_state)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Model: word array, a not-ready window [busy_from, ready_at), and
   // expected responses with the cycle each must appear in.
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] boot_words [8] = '{32'h0000_0000, 32'h2129_000A, 32'h214A_0005, 32'h0000_0000,
                                     32'h0000_0000, 32'h0000_0000, 32'h012A_4020, 32'h2108_000A};
   int busy_from = 0;
   int ready_at  = 1 << 30;
   logic [DW-1:0] exp_q[$];
   int            due_q[$];

   function automatic bit exp_ready_now(input int c);
      return !(c >= busy_from && c < ready_at);
   endfunction

   function automatic void model_init();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`ifdef RAM_BOOT_PROGRAM_EN
      for (int k = 0; k < 8; k++) model_mem[k] = boot_words[k];
`endif
   endfunction

   always @(negedge clock) begin : monitor
      bit            er;
      bit            ev;
      logic [DW-1:0] ed;
      er = exp_ready_now(cyc);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         ev = 1'b1;
         ed = exp_q.pop_front();
         void'(due_q.pop_front());
      end else begin
         ev = 1'b0;
         ed = '0;
      end
      checks++;
      assert (req_ready === er) else begin
         failures++;
         $error("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
      end
      checks++;
      assert (init_busy === !er) else begin
         failures++;
         $error("FAIL init_busy cyc=%0d got=%b exp=%b", cyc, init_busy, !er);
      end
      checks++;
      assert ((dbg_state === 2'(ST_READY)) === er) else begin
         failures++;
         $error("FAIL dbg_state cyc=%0d got=%0d exp_ready=%b", cyc, dbg_state, er);
      end
      checks++;
      assert (rsp_valid === ev) else begin
         failures++;
         $error("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev);
      end
      checks++;
      assert (rsp_rdata === ed) else begin
         failures++;
         $error("FAIL rsp_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata, ed);
      end
   end

   task automatic drive_cycle(input bit v, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [3:0] be, input bit init);
      bit acc;
      @(posedge clock);
      #1;
      req_valid = v;
      req_we    = we;
      req_addr  = addr;
      req_wdata = data;
      req_be    = be;
      init_req  = init;
      acc = exp_ready_now(cyc);
      if (v && acc) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) model_mem[addr][8*b +: 8] = data[8*b +: 8];
         end else begin
            exp_q.push_back(model_mem[addr]);
            due_q.push_back(cyc + LAT);
         end
      end
      if (init && acc) begin
         busy_from = cyc + 1;
         ready_at  = cyc + 1 + INIT;
         model_init();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] addr);
      drive_cycle(1'b1, 1'b0, addr, '0, '0, 1'b0);
   endtask

   task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] be);
      drive_cycle(1'b1, 1'b1, addr, data, be, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clock);
      #1;
      reset     = 1'b1;
      req_valid = 1'b0;
      init_req  = 1'b0;
      exp_q.delete();
      due_q.delete();
      busy_from = 0;
      ready_at  = 1 << 30;
      repeat (n) @(posedge clock);
      #1;
      reset    = 1'b0;
      ready_at = cyc + INIT;
      model_init();
   endtask

   initial begin
      do_reset(3);
      idle(INIT + 2);
      for (int a = 0; a < DEPTH; a++) rd(7'(a));
      idle(LAT + 2);

      wr(7'd5, 32'hDEAD_BEEF, 4'hF);
      rd(7'd5);
      idle(LAT + 2);

      wr(7'd9, 32'hFFFF_FFFF, 4'hF);
      wr(7'd9, 32'h1234_5678, 4'b0101);
      rd(7'd9);
      idle(LAT + 2);

      for (int a = 0; a < 16; a++) wr(7'(a + 32), $urandom, 4'hF);
      wr(7'd40, 32'hCAFE_F00D, 4'h0);
      for (int a = 0; a < 16; a++) rd(7'(a + 32));
      idle(LAT + 2);

      for (int i = 0; i < 300; i++) begin
         drive_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     7'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
      end
      idle(LAT + 2);

      wr(7'd5, 32'h0BAD_CAFE, 4'hF);
      rd(7'd5);
      rd(7'd9);
      drive_cycle(1'b1, 1'b0, 7'd5, '0, '0, 1'b1);
      idle(60);
      rd(7'd9);
      drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
      idle(INIT);
      rd(7'd9);
      rd(7'd5);
      rd(7'd1);
      idle(LAT + 2);

      wr(7'd20, 32'h5555_AAAA, 4'hF);
      rd(7'd20);
      rd(7'd5);
      do_reset(2);
      idle(INIT + 2);
      rd(7'd20);
      rd(7'd2);
      idle(LAT + 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
